policy_generator: RTL

Epsilon-greedy action selector for the Q-learning accelerator, sitting directly downstream of the control unit (CU). On each CU request it draws a pseudo-random number from an internal LFSR and compares it with the CU's current epsilon. It then returns either a random action (explore) or the arg-max action over the current state's Q-values (exploit). The result feeds the environment/Q-update datapath.

---
 rtl/policy_generator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/policy_generator.sv
// Epsilon-greedy action selector: draws a pseudo-random number from a 16-bit
// Galois LFSR and returns either a random action (explore) or the arg-max
// action over the supplied Q-values (exploit, one comparison per cycle).
module policy_generator #(
    parameter int N_ACT     = 4,
    parameter int A_WIDTH   = 2,
    parameter int Q_WIDTH   = 16,
    parameter int RND_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RND_WIDTH-1:0]     seed,
    input  logic                     seed_ld,
    input  logic [RND_WIDTH-1:0]     epsilon,
    input  logic                     mode,
    input  logic                     start,
    input  logic [N_ACT*Q_WIDTH-1:0] q_in,
    output logic [A_WIDTH-1:0]       action,
    output logic                     explore,
    output logic                     done,
    output logic                     busy,
    output logic [RND_WIDTH-1:0]     debug_rnd
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SCAN,
        DONE
    } state_t;

    localparam logic [RND_WIDTH-1:0] LFSR_TAPS = RND_WIDTH'(16'hB400);
    localparam logic [RND_WIDTH-1:0] LFSR_ONE  = RND_WIDTH'(1);
    localparam logic [A_WIDTH-1:0]   LAST_IDX  = A_WIDTH'(N_ACT - 1);

    state_t                      state;
    state_t                      state_next;
    logic [RND_WIDTH-1:0]        lfsr;
    logic [RND_WIDTH-1:0]        lfsr_next;
    logic signed [Q_WIDTH-1:0]   best_q;
    logic signed [Q_WIDTH-1:0]   q_cur;
    logic [A_WIDTH-1:0]          best_idx;
    logic [A_WIDTH-1:0]          idx;
    logic                        take_explore;
    logic                        q_better;

    // Galois right-shift step; a zero state is never loaded, so no lock-up.
    assign lfsr_next    = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    // Q-value of the action currently being scanned.
    assign q_cur        = $signed(q_in[int'(idx)*Q_WIDTH +: Q_WIDTH]);
    assign take_explore = !mode && (lfsr < epsilon);
    // Strict compare keeps the lowest index on ties.
    assign q_better     = q_cur > best_q;

    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign debug_rnd = lfsr;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; seed_ld wins over start in IDLE.
    always_comb begin
        // NOTE: default first, so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!seed_ld && start) begin
                    state_next = DRAW;
                end
            end
            DRAW: state_next = take_explore ? DONE : SCAN;
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: LFSR, result registers and the arg-max scan.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr     <= LFSR_ONE;
            action   <= '0;
            explore  <= 1'b0;
            best_q   <= '0;
            best_idx <= '0;
            idx      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (seed_ld) begin
                        lfsr <= (seed == '0) ? LFSR_ONE : seed;
                    end else if (start) begin
                        lfsr <= lfsr_next;
                    end
                end
                DRAW: begin
                    if (take_explore) begin
                        action  <= lfsr[A_WIDTH-1:0];
                        explore <= 1'b1;
                    end else begin
                        best_q   <= $signed(q_in[Q_WIDTH-1:0]);
                        best_idx <= '0;
                        idx      <= A_WIDTH'(1);
                        explore  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (q_better) begin
                        best_q   <= q_cur;
                        best_idx <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        action <= q_better ? idx : best_idx;
                    end else begin
                        idx <= idx + A_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
